// File: rtl/alu_pkg.sv
`default_nettype none
//============================================================================
// Module   : alu_pkg
// Brief    : Shared constants, opcode encodings, FSM states and the
//            operand-need decoder for the alu_core block.
// Revision : 1.0 - initial release
//============================================================================
package alu_pkg;

    localparam int OP_WIDTH  = 8;
    localparam int CMD_WIDTH = 4;
    localparam int SHIFT_W   = $clog2(OP_WIDTH);
    localparam int TIMEOUT   = 16;
    localparam int CNT_W     = $clog2(TIMEOUT);

    typedef enum logic [CMD_WIDTH-1:0] {
        A_ADD     = 4'd0,
        A_SUB     = 4'd1,
        A_ADD_CIN = 4'd2,
        A_SUB_CIN = 4'd3,
        A_INC_A   = 4'd4,
        A_DEC_A   = 4'd5,
        A_INC_B   = 4'd6,
        A_DEC_B   = 4'd7,
        A_CMP     = 4'd8
    } arith_op_t;

    typedef enum logic [CMD_WIDTH-1:0] {
        L_AND   = 4'd0,
        L_NAND  = 4'd1,
        L_OR    = 4'd2,
        L_NOR   = 4'd3,
        L_XOR   = 4'd4,
        L_XNOR  = 4'd5,
        L_NOT_A = 4'd6,
        L_NOT_B = 4'd7,
        L_SHR_A = 4'd8,
        L_SHL_A = 4'd9,
        L_SHR_B = 4'd10,
        L_SHL_B = 4'd11,
        L_ROL   = 4'd12,
        L_ROR   = 4'd13
    } logic_op_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT_A = 2'd1,
        WAIT_B = 2'd2
    } fsm_state_t;

    // Returns {need_a, need_b}; illegal opcodes need both so they still
    // resolve (to an error) through the normal collection path.
    function automatic logic [1:0] need_ops(input logic mode,
                                            input logic [CMD_WIDTH-1:0] cmd);
        logic [1:0] need;
        need = 2'b11;
        if (mode) begin
            if (cmd == A_INC_A || cmd == A_DEC_A)
                need = 2'b10;
            else if (cmd == A_INC_B || cmd == A_DEC_B)
                need = 2'b01;
        end else begin
            if (cmd == L_NOT_A || cmd == L_SHR_A || cmd == L_SHL_A)
                need = 2'b10;
            else if (cmd == L_NOT_B || cmd == L_SHR_B || cmd == L_SHL_B)
                need = 2'b01;
        end
        return need;
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_core_if.sv
`default_nettype none
//============================================================================
// Module   : alu_core_if
// Brief    : Driver/monitor bus of the ALU: operand stream in, registered
//            result and flags out.
// Revision : 1.0 - initial release
//============================================================================
interface alu_core_if;
    import alu_pkg::*;

    logic                 CE;
    logic [1:0]           INP_VALID;
    logic                 MODE;
    logic [CMD_WIDTH-1:0] CMD;
    logic [OP_WIDTH-1:0]  OPA;
    logic [OP_WIDTH-1:0]  OPB;
    logic                 CIN;
    logic [OP_WIDTH:0]    RES;
    logic                 ERR;
    logic                 OFLOW;
    logic                 COUT;
    logic                 G;
    logic                 L;
    logic                 E;

    modport master (
        output CE, INP_VALID, MODE, CMD, OPA, OPB, CIN,
        input  RES, ERR, OFLOW, COUT, G, L, E
    );

    modport slave (
        input  CE, INP_VALID, MODE, CMD, OPA, OPB, CIN,
        output RES, ERR, OFLOW, COUT, G, L, E
    );
endinterface
`default_nettype wire

// File: rtl/alu_exec.sv
`default_nettype none
//============================================================================
// Module   : alu_exec
// Brief    : Combinational ALU datapath: result, flags and error for one
//            fully assembled (mode, cmd, a, b, cin) operation.
// Revision : 1.0 - initial release
//============================================================================
module alu_exec
    import alu_pkg::*;
(
    input  logic                 i_mode,
    input  logic [CMD_WIDTH-1:0] i_cmd,
    input  logic [OP_WIDTH-1:0]  i_a,
    input  logic [OP_WIDTH-1:0]  i_b,
    input  logic                 i_cin,
    output logic [OP_WIDTH:0]    o_res,
    output logic                 o_err,
    output logic                 o_oflow,
    output logic                 o_cout,
    output logic                 o_g,
    output logic                 o_l,
    output logic                 o_e
);
    localparam logic [OP_WIDTH:0] c_one   = (OP_WIDTH+1)'(1);
    localparam logic [SHIFT_W:0]  c_width = (SHIFT_W+1)'(OP_WIDTH);

    logic [OP_WIDTH:0]   w_a9;
    logic [OP_WIDTH:0]   w_b9;
    logic [OP_WIDTH:0]   w_c9;
    logic [SHIFT_W-1:0]  w_amt;
    logic                w_amt_bad;
    logic [OP_WIDTH-1:0] w_rol;
    logic [OP_WIDTH-1:0] w_ror;

    assign w_a9      = {1'b0, i_a};
    assign w_b9      = {1'b0, i_b};
    assign w_c9      = {{OP_WIDTH{1'b0}}, i_cin};
    assign w_amt     = i_b[SHIFT_W-1:0];
    // Rotate amounts beyond the operand width are rejected, not wrapped.
    assign w_amt_bad = |i_b[OP_WIDTH-1:SHIFT_W];
    // A shift by the full width yields zero, so amount 0 needs no special case.
    assign w_rol     = (i_a << w_amt) | (i_a >> (c_width - {1'b0, w_amt}));
    assign w_ror     = (i_a >> w_amt) | (i_a << (c_width - {1'b0, w_amt}));

    // Decode the opcode into result and flags; errors leave everything else zero.
    always_comb begin
        o_res   = '0;
        o_err   = 1'b0;
        o_oflow = 1'b0;
        o_cout  = 1'b0;
        o_g     = 1'b0;
        o_l     = 1'b0;
        o_e     = 1'b0;
        if (i_mode) begin
            case (i_cmd)
                A_ADD:     o_res = w_a9 + w_b9;
                A_SUB: begin
                    o_res   = w_a9 - w_b9;
                    o_oflow = (i_a < i_b);
                end
                A_ADD_CIN: o_res = w_a9 + w_b9 + w_c9;
                A_SUB_CIN: begin
                    o_res   = w_a9 - w_b9 - w_c9;
                    o_oflow = (w_a9 < (w_b9 + w_c9));
                end
                A_INC_A:   o_res = w_a9 + c_one;
                A_DEC_A:   o_res = w_a9 - c_one;
                A_INC_B:   o_res = w_b9 + c_one;
                A_DEC_B:   o_res = w_b9 - c_one;
                A_CMP: begin
                    o_g = (i_a > i_b);
                    o_l = (i_a < i_b);
                    o_e = (i_a == i_b);
                end
                default:   o_err = 1'b1;
            endcase
            // The ninth result bit is the carry/borrow out of the arithmetic.
            o_cout = o_res[OP_WIDTH];
        end else begin
            case (i_cmd)
                L_AND:   o_res = {1'b0, i_a & i_b};
                L_NAND:  o_res = {1'b0, ~(i_a & i_b)};
                L_OR:    o_res = {1'b0, i_a | i_b};
                L_NOR:   o_res = {1'b0, ~(i_a | i_b)};
                L_XOR:   o_res = {1'b0, i_a ^ i_b};
                L_XNOR:  o_res = {1'b0, ~(i_a ^ i_b)};
                L_NOT_A: o_res = {1'b0, ~i_a};
                L_NOT_B: o_res = {1'b0, ~i_b};
                L_SHR_A: o_res = {1'b0, i_a >> 1};
                L_SHL_A: o_res = {1'b0, i_a << 1};
                L_SHR_B: o_res = {1'b0, i_b >> 1};
                L_SHL_B: o_res = {1'b0, i_b << 1};
                L_ROL: begin
                    if (w_amt_bad) o_err = 1'b1;
                    else           o_res = {1'b0, w_rol};
                end
                L_ROR: begin
                    if (w_amt_bad) o_err = 1'b1;
                    else           o_res = {1'b0, w_ror};
                end
                default: o_err = 1'b1;
            endcase
        end
    end
endmodule
`default_nettype wire

// File: rtl/alu_core.sv
`default_nettype none
//============================================================================
// Module   : alu_core
// Brief    : Cycle-based ALU top: collects operands that may arrive split
//            across cycles (with timeout), executes and registers results.
// Revision : 1.0 - initial release
//============================================================================
module alu_core
    import alu_pkg::*;
(
    input  logic       clk,
    input  logic       RST,
    alu_core_if.slave  bus
);
    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(TIMEOUT - 1);

    fsm_state_t           r_state, w_nxt_state;
    logic [CNT_W-1:0]     r_cnt, w_nxt_cnt;
    logic                 r_mode, w_nxt_mode;
    logic [CMD_WIDTH-1:0] r_cmd, w_nxt_cmd;
    logic [OP_WIDTH-1:0]  r_opa, w_nxt_opa;
    logic [OP_WIDTH-1:0]  r_opb, w_nxt_opb;
    logic                 r_cin, w_nxt_cin;
    logic [OP_WIDTH:0]    r_res, w_nxt_res;
    logic                 r_err, w_nxt_err;
    logic                 r_oflow, w_nxt_oflow;
    logic                 r_cout, w_nxt_cout;
    logic                 r_g, w_nxt_g;
    logic                 r_l, w_nxt_l;
    logic                 r_e, w_nxt_e;

    logic                 w_ex_mode;
    logic [CMD_WIDTH-1:0] w_ex_cmd;
    logic [OP_WIDTH-1:0]  w_ex_a;
    logic [OP_WIDTH-1:0]  w_ex_b;
    logic                 w_ex_cin;
    logic [OP_WIDTH:0]    w_ex_res;
    logic                 w_ex_err, w_ex_oflow, w_ex_cout, w_ex_g, w_ex_l, w_ex_e;
    logic [1:0]           w_need;
    logic                 w_covered;
    logic                 w_take_ex;
    logic                 w_take_err;

    // While waiting, the command and the already-held operand come from the
    // latches; only the missing operand is taken from the bus.
    assign w_ex_mode = (r_state == IDLE)   ? bus.MODE : r_mode;
    assign w_ex_cmd  = (r_state == IDLE)   ? bus.CMD  : r_cmd;
    assign w_ex_cin  = (r_state == IDLE)   ? bus.CIN  : r_cin;
    assign w_ex_a    = (r_state == WAIT_B) ? r_opa    : bus.OPA;
    assign w_ex_b    = (r_state == WAIT_A) ? r_opb    : bus.OPB;

    assign w_need    = need_ops(bus.MODE, bus.CMD);
    assign w_covered = ~(w_need[1] & ~bus.INP_VALID[0]) &
                       ~(w_need[0] & ~bus.INP_VALID[1]);

    alu_exec u_exec (
        .i_mode  (w_ex_mode),
        .i_cmd   (w_ex_cmd),
        .i_a     (w_ex_a),
        .i_b     (w_ex_b),
        .i_cin   (w_ex_cin),
        .o_res   (w_ex_res),
        .o_err   (w_ex_err),
        .o_oflow (w_ex_oflow),
        .o_cout  (w_ex_cout),
        .o_g     (w_ex_g),
        .o_l     (w_ex_l),
        .o_e     (w_ex_e)
    );

    // Next-state, operand latching, timeout counting and output selection.
    always_comb begin
        w_nxt_state = r_state;
        w_nxt_cnt   = r_cnt;
        w_nxt_mode  = r_mode;
        w_nxt_cmd   = r_cmd;
        w_nxt_opa   = r_opa;
        w_nxt_opb   = r_opb;
        w_nxt_cin   = r_cin;
        w_nxt_res   = r_res;
        w_nxt_err   = r_err;
        w_nxt_oflow = r_oflow;
        w_nxt_cout  = r_cout;
        w_nxt_g     = r_g;
        w_nxt_l     = r_l;
        w_nxt_e     = r_e;
        w_take_ex   = 1'b0;
        w_take_err  = 1'b0;

        case (r_state)
            IDLE: begin
                if (bus.INP_VALID == 2'b00) begin
                    w_take_err = 1'b1;
                end else if (w_covered) begin
                    w_take_ex = 1'b1;
                end else if (w_need == 2'b11 && bus.INP_VALID == 2'b01) begin
                    w_nxt_opa   = bus.OPA;
                    w_nxt_mode  = bus.MODE;
                    w_nxt_cmd   = bus.CMD;
                    w_nxt_cin   = bus.CIN;
                    w_nxt_cnt   = '0;
                    w_nxt_state = WAIT_B;
                end else if (w_need == 2'b11 && bus.INP_VALID == 2'b10) begin
                    w_nxt_opb   = bus.OPB;
                    w_nxt_mode  = bus.MODE;
                    w_nxt_cmd   = bus.CMD;
                    w_nxt_cin   = bus.CIN;
                    w_nxt_cnt   = '0;
                    w_nxt_state = WAIT_A;
                end else begin
                    // Single-operand command offered only the wrong operand.
                    w_take_err = 1'b1;
                end
            end
            WAIT_A, WAIT_B: begin
                if ((r_state == WAIT_A && bus.INP_VALID[0]) ||
                    (r_state == WAIT_B && bus.INP_VALID[1])) begin
                    w_take_ex   = 1'b1;
                    w_nxt_state = IDLE;
                end else if (r_cnt == c_cnt_last) begin
                    w_take_err  = 1'b1;
                    w_nxt_state = IDLE;
                end else begin
                    w_nxt_cnt = r_cnt + 1'b1;
                end
            end
            default: w_nxt_state = IDLE;
        endcase

        if (w_take_ex) begin
            w_nxt_res   = w_ex_res;
            w_nxt_err   = w_ex_err;
            w_nxt_oflow = w_ex_oflow;
            w_nxt_cout  = w_ex_cout;
            w_nxt_g     = w_ex_g;
            w_nxt_l     = w_ex_l;
            w_nxt_e     = w_ex_e;
        end else if (w_take_err) begin
            w_nxt_res   = '0;
            w_nxt_err   = 1'b1;
            w_nxt_oflow = 1'b0;
            w_nxt_cout  = 1'b0;
            w_nxt_g     = 1'b0;
            w_nxt_l     = 1'b0;
            w_nxt_e     = 1'b0;
        end
    end

    // State, latches, counter and outputs: reset wins over CE, CE=0 freezes all.
    always_ff @(posedge clk) begin
        if (!RST) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_mode  <= 1'b0;
            r_cmd   <= '0;
            r_opa   <= '0;
            r_opb   <= '0;
            r_cin   <= 1'b0;
            r_res   <= '0;
            r_err   <= 1'b0;
            r_oflow <= 1'b0;
            r_cout  <= 1'b0;
            r_g     <= 1'b0;
            r_l     <= 1'b0;
            r_e     <= 1'b0;
        end else if (bus.CE) begin
            r_state <= w_nxt_state;
            r_cnt   <= w_nxt_cnt;
            r_mode  <= w_nxt_mode;
            r_cmd   <= w_nxt_cmd;
            r_opa   <= w_nxt_opa;
            r_opb   <= w_nxt_opb;
            r_cin   <= w_nxt_cin;
            r_res   <= w_nxt_res;
            r_err   <= w_nxt_err;
            r_oflow <= w_nxt_oflow;
            r_cout  <= w_nxt_cout;
            r_g     <= w_nxt_g;
            r_l     <= w_nxt_l;
            r_e     <= w_nxt_e;
        end
    end

    assign bus.RES   = r_res;
    assign bus.ERR   = r_err;
    assign bus.OFLOW = r_oflow;
    assign bus.COUT  = r_cout;
    assign bus.G     = r_g;
    assign bus.L     = r_l;
    assign bus.E     = r_e;
endmodule
`default_nettype wire

// File: tb/tb_alu_core.sv
`default_nettype none
//============================================================================
// Module   : tb_alu_core
// Brief    : Self-checking bench for alu_core: directed scenarios plus
//            randomized traffic against a behavioural reference model.
// Revision : 1.0 - initial release
//============================================================================
module tb_alu_core;
    import alu_pkg::*;

    localparam logic [14:0] c_err_only = 15'h020;

    logic clk = 1'b0;
    logic tb_rst;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    alu_core_if bus ();

    alu_core dut (
        .clk (clk),
        .RST (tb_rst),
        .bus (bus)
    );

    // Observed outputs packed as {RES, ERR, OFLOW, COUT, G, L, E}.
    logic [14:0] dut_out;
    assign dut_out = {bus.RES, bus.ERR, bus.OFLOW, bus.COUT, bus.G, bus.L, bus.E};

    // Reference model state: pending half-operation and its age in cycles.
    logic [14:0] exp_out;
    int          pend;      // 0 none, 1 holds A awaiting B, 2 holds B awaiting A
    int          age;
    logic        p_mode;
    logic [3:0]  p_cmd;
    logic [7:0]  p_a;
    logic [7:0]  p_b;
    logic        p_cin;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // {need_a, need_b} straight from the opcode table.
    function automatic logic [1:0] tb_need(input logic mode, input logic [3:0] cmd);
        if (mode) begin
            if (cmd == 4 || cmd == 5) return 2'b10;
            if (cmd == 6 || cmd == 7) return 2'b01;
        end else begin
            if (cmd == 6 || cmd == 8 || cmd == 9)   return 2'b10;
            if (cmd == 7 || cmd == 10 || cmd == 11) return 2'b01;
        end
        return 2'b11;
    endfunction

    // Integer-arithmetic reference for one complete operation.
    function automatic logic [14:0] ref_alu(input logic mode, input logic [3:0] cmd,
                                            input logic [7:0] a, input logic [7:0] b,
                                            input logic cin);
        int ai, bi, ci, r;
        logic err, of, g, l, e;
        logic [8:0] res;
        ai = int'(a); bi = int'(b); ci = cin ? 1 : 0; r = 0;
        err = 1'b0; of = 1'b0; g = 1'b0; l = 1'b0; e = 1'b0;
        if (mode) begin
            case (cmd)
                0: r = ai + bi;
                1: begin r = ai - bi; of = (ai < bi); end
                2: r = ai + bi + ci;
                3: begin r = ai - bi - ci; of = (r < 0); end
                4: r = ai + 1;
                5: r = ai - 1;
                6: r = bi + 1;
                7: r = bi - 1;
                8: begin g = (ai > bi); l = (ai < bi); e = (ai == bi); end
                default: err = 1'b1;
            endcase
            if (err) return c_err_only;
            res = 9'(r & 511);
            return {res, 1'b0, of, res[8], g, l, e};
        end
        case (cmd)
            0:  r = ai & bi;
            1:  r = 255 - (ai & bi);
            2:  r = ai | bi;
            3:  r = 255 - (ai | bi);
            4:  r = ai ^ bi;
            5:  r = 255 - (ai ^ bi);
            6:  r = 255 - ai;
            7:  r = 255 - bi;
            8:  r = ai / 2;
            9:  r = (ai * 2) % 256;
            10: r = bi / 2;
            11: r = (bi * 2) % 256;
            12, 13: begin
                if (bi > 7) err = 1'b1;
                else begin
                    r = ai;
                    for (int k = 0; k < bi; k++)
                        r = (cmd == 12) ? ((r * 2) % 256 + r / 128) : (r / 2 + (r % 2) * 128);
                end
            end
            default: err = 1'b1;
        endcase
        if (err) return c_err_only;
        return {9'(r), 6'b000000};
    endfunction

    // Advance the model by one clock edge using the currently driven inputs.
    task automatic model_edge();
        logic [1:0] nd, v;
        v = bus.INP_VALID;
        if (!tb_rst) begin
            pend = 0; age = 0; exp_out = '0;
        end else if (bus.CE) begin
            if (pend == 0) begin
                nd = tb_need(bus.MODE, bus.CMD);
                if (v == 2'b00)
                    exp_out = c_err_only;
                else if ((!nd[1] || v[0]) && (!nd[0] || v[1]))
                    exp_out = ref_alu(bus.MODE, bus.CMD, bus.OPA, bus.OPB, bus.CIN);
                else if (nd == 2'b11) begin
                    pend = v[0] ? 1 : 2;
                    p_mode = bus.MODE; p_cmd = bus.CMD; p_cin = bus.CIN;
                    p_a = bus.OPA; p_b = bus.OPB; age = 0;
                end else
                    exp_out = c_err_only;
            end else if ((pend == 1 && v[1]) || (pend == 2 && v[0])) begin
                exp_out = ref_alu(p_mode, p_cmd, (pend == 1) ? p_a : bus.OPA,
                                  (pend == 1) ? bus.OPB : p_b, p_cin);
                pend = 0;
            end else begin
                age++;
                if (age >= TIMEOUT) begin
                    exp_out = c_err_only;
                    pend = 0;
                end
            end
        end
    endtask

    task automatic drive(input logic ce, input logic [1:0] v, input logic mode,
                         input logic [3:0] cmd, input logic [7:0] a,
                         input logic [7:0] b, input logic cin);
        bus.CE = ce; bus.INP_VALID = v; bus.MODE = mode; bus.CMD = cmd;
        bus.OPA = a; bus.OPB = b; bus.CIN = cin;
    endtask

    task automatic cycle(input string tag);
        model_edge();
        @(posedge clk);
        #1;
        check(tag, 32'(dut_out), 32'(exp_out));
    endtask

    initial begin
        logic [1:0] nd, v;
        int         sel;
        pend = 0; age = 0; exp_out = '0;
        p_mode = 1'b0; p_cmd = '0; p_a = '0; p_b = '0; p_cin = 1'b0;

        // Reset held for two cycles with live traffic on the inputs.
        tb_rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 2'b11, 1'b1, 4'd0, 8'($urandom), 8'($urandom), 1'b1);
            cycle("reset_cycle");
        end
        check("reset_all_zero", 32'(dut_out), 32'd0);

        tb_rst = 1'b1;
        drive(1'b1, 2'b11, 1'b1, 4'd0, 8'hFF, 8'h01, 1'b0);
        cycle("add_ff_01");
        check("add_carry", 32'({bus.RES, bus.COUT}), 32'({9'h100, 1'b1}));

        // Split operands: A now, B three cycles later.
        drive(1'b1, 2'b01, 1'b1, 4'd1, 8'h05, 8'hEE, 1'b0);
        cycle("split_latch");
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 2'b00, 1'b0, 4'd9, 8'($urandom), 8'($urandom), 1'b1);
            cycle("split_wait");
        end
        check("split_hold", 32'(dut_out), 32'({9'h100, 6'b001000}));
        drive(1'b1, 2'b10, 1'b0, 4'd3, 8'hAA, 8'h07, 1'b1);
        cycle("split_done");
        check("split_sub", 32'({bus.RES, bus.OFLOW, bus.ERR}), 32'({9'h1FE, 1'b1, 1'b0}));

        // Timeout after 16 waiting cycles.
        drive(1'b1, 2'b10, 1'b0, 4'd0, 8'h00, 8'h33, 1'b0);
        cycle("tmo_latch");
        for (int i = 0; i < TIMEOUT; i++) begin
            drive(1'b1, 2'b00, 1'b0, 4'd0, 8'h00, 8'h00, 1'b0);
            cycle("tmo_wait");
        end
        check("timeout_err", 32'({bus.ERR, bus.RES}), 32'({1'b1, 9'h000}));
        drive(1'b1, 2'b11, 1'b0, 4'd0, 8'hF0, 8'h3C, 1'b0);
        cycle("post_timeout");
        check("post_timeout_and", 32'({bus.ERR, bus.RES}), 32'({1'b0, 9'h030}));

        // Clock-enable freeze while waiting for B.
        drive(1'b1, 2'b01, 1'b1, 4'd0, 8'h10, 8'h00, 1'b0);
        cycle("ce_latch");
        for (int i = 0; i < 30; i++) begin
            drive(1'b0, 2'($urandom), 1'($urandom), 4'($urandom), 8'($urandom), 8'($urandom), 1'b0);
            cycle("ce_frozen");
        end
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 2'b00, 1'b0, 4'd0, 8'h00, 8'h00, 1'b0);
            cycle("ce_resume");
        end
        drive(1'b1, 2'b10, 1'b0, 4'd0, 8'h00, 8'h20, 1'b0);
        cycle("ce_done");
        check("freeze_result", 32'({bus.ERR, bus.RES}), 32'({1'b0, 9'h030}));

        // Rotate legal and illegal amounts.
        drive(1'b1, 2'b11, 1'b0, 4'd12, 8'h81, 8'h01, 1'b0);
        cycle("rol_1");
        check("rol_res", 32'({bus.ERR, bus.RES}), 32'({1'b0, 9'h003}));
        drive(1'b1, 2'b11, 1'b0, 4'd12, 8'h81, 8'h10, 1'b0);
        cycle("rol_bad");
        check("rol_bad_err", 32'({bus.ERR, bus.RES}), 32'({1'b1, 9'h000}));

        // Illegal arithmetic opcode and equal compare.
        drive(1'b1, 2'b11, 1'b1, 4'd11, 8'h12, 8'h34, 1'b0);
        cycle("illegal");
        check("illegal_err", 32'(bus.ERR), 32'd1);
        drive(1'b1, 2'b11, 1'b1, 4'd8, 8'h42, 8'h42, 1'b0);
        cycle("cmp_eq");
        check("cmp_gle", 32'({bus.RES, bus.G, bus.L, bus.E, bus.ERR}), 32'({9'h000, 3'b001, 1'b0}));

        // Randomized traffic against the reference model.
        for (int it = 0; it < 500; it++) begin
            tb_rst        = ($urandom_range(0, 63) != 0);
            bus.CE        = ($urandom_range(0, 7) != 0);
            bus.MODE      = 1'($urandom);
            bus.CMD       = 4'($urandom_range(0, 15));
            bus.OPA       = 8'($urandom);
            bus.OPB       = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 7)) : 8'($urandom);
            bus.CIN       = 1'($urandom);
            if (pend == 0) begin
                nd  = tb_need(bus.MODE, bus.CMD);
                sel = $urandom_range(0, 5);
                if (sel == 0)
                    v = 2'b00;
                else if (sel == 1)
                    v = 2'b11;
                else if (nd == 2'b11)
                    v = (sel <= 3) ? (($urandom_range(0, 1) != 0) ? 2'b01 : 2'b10) : 2'b11;
                else
                    v = (nd == 2'b10) ? 2'b01 : 2'b10;
            end else begin
                v = ($urandom_range(0, 11) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            end
            bus.INP_VALID = v;
            cycle("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
